// File: rtl/overlay_update_ctrl.sv
// overlay_update_ctrl: shadows centroid/bbox updates and commits them at frame start,
// then issues a one-cycle update strobe; silent sources are retired off-screen.
module overlay_update_ctrl #(
    parameter int IMG_W        = 1280,
    parameter int IMG_H        = 720,
    parameter int STALE_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        v_sync_in,
    input  logic        enable,
    input  logic        c_valid,
    output logic        c_ready,
    input  logic [10:0] c_x,
    input  logic [10:0] c_y,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [10:0] b_min_x,
    input  logic [10:0] b_max_x,
    input  logic [10:0] b_min_y,
    input  logic [10:0] b_max_y,
    output logic        valid_out,
    output logic [10:0] x_out,
    output logic [10:0] y_out,
    output logic [10:0] min_x_out,
    output logic [10:0] max_x_out,
    output logic [10:0] min_y_out,
    output logic [10:0] max_y_out,
    output logic        c_stale,
    output logic        b_stale
);
    localparam logic [10:0] XM  = 11'(IMG_W - 1);
    localparam logic [10:0] YM  = 11'(IMG_H - 1);
    localparam logic [7:0]  SF  = 8'(STALE_FRAMES);
    localparam logic [10:0] OFF = 11'h7FF;

    typedef enum logic [1:0] {IDLE, LOAD, PULSE} state_t;
    state_t state_q, state_d;

    logic        vs_q, fs, commit, c_acc, b_acc, c_pend_q, b_pend_q;
    logic [7:0]  c_cnt_q, c_cnt_d, b_cnt_q, b_cnt_d;
    logic [10:0] cx, cy, bx0, bx1, by0, by1;
    logic [10:0] c_x_q, c_y_q, b_nx_q, b_xx_q, b_ny_q, b_xy_q;

    assign fs        = v_sync_in & ~vs_q;
    assign commit    = fs & enable & (state_q == IDLE);
    assign c_ready   = rst_n & (state_q != LOAD);
    assign b_ready   = rst_n & (state_q != LOAD);
    assign c_acc     = c_valid & c_ready;
    assign b_acc     = b_valid & b_ready;
    assign valid_out = state_q == PULSE;

    always_comb begin
        cx      = c_x > XM ? XM : c_x;
        cy      = c_y > YM ? YM : c_y;
        bx0     = b_min_x > XM ? XM : b_min_x;
        bx1     = b_max_x > XM ? XM : b_max_x;
        by0     = b_min_y > YM ? YM : b_min_y;
        by1     = b_max_y > YM ? YM : b_max_y;
        c_cnt_d = c_acc ? 8'd0 : (fs && c_cnt_q != SF) ? c_cnt_q + 8'd1 : c_cnt_q;
        b_cnt_d = b_acc ? 8'd0 : (fs && b_cnt_q != SF) ? b_cnt_q + 8'd1 : b_cnt_q;
        state_d = state_q == LOAD ? PULSE : state_q == PULSE ? IDLE : commit ? LOAD : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vs_q      <= 1'b1;
            c_cnt_q   <= SF;
            b_cnt_q   <= SF;
            c_pend_q  <= 1'b1;
            b_pend_q  <= 1'b1;
            c_x_q     <= '0;
            c_y_q     <= '0;
            b_nx_q    <= '0;
            b_xx_q    <= '0;
            b_ny_q    <= '0;
            b_xy_q    <= '0;
            x_out     <= OFF;
            y_out     <= OFF;
            min_x_out <= OFF;
            max_x_out <= OFF;
            min_y_out <= OFF;
            max_y_out <= OFF;
            c_stale   <= 1'b1;
            b_stale   <= 1'b1;
        end else begin
            state_q <= state_d;
            vs_q    <= v_sync_in;
            c_cnt_q <= c_cnt_d;
            b_cnt_q <= b_cnt_d;
            if (c_acc) begin
                c_x_q <= cx;
                c_y_q <= cy;
            end
            if (b_acc) begin
                b_nx_q <= bx0 > bx1 ? bx1 : bx0;
                b_xx_q <= bx0 > bx1 ? bx0 : bx1;
                b_ny_q <= by0 > by1 ? by1 : by0;
                b_xy_q <= by0 > by1 ? by0 : by1;
            end
            // staleness is judged on pre-increment counts; a same-cycle acceptance counts as fresh
            if (commit) begin
                c_pend_q <= ~c_acc & (c_cnt_q == SF);
                b_pend_q <= ~b_acc & (b_cnt_q == SF);
            end
            if (state_q == LOAD) begin
                x_out     <= c_pend_q ? OFF : c_x_q;
                y_out     <= c_pend_q ? OFF : c_y_q;
                min_x_out <= b_pend_q ? OFF : b_nx_q;
                max_x_out <= b_pend_q ? OFF : b_xx_q;
                min_y_out <= b_pend_q ? OFF : b_ny_q;
                max_y_out <= b_pend_q ? OFF : b_xy_q;
                c_stale   <= c_pend_q;
                b_stale   <= b_pend_q;
            end
        end
    end
endmodule

// File: tb/tb_overlay_update_ctrl.sv
// tb_overlay_update_ctrl: scoreboard bench; expected commits are queued at each frame start
// and checked when valid_out pulses.
module tb_overlay_update_ctrl;
    localparam logic [10:0] XM = 11'd1279;
    localparam logic [10:0] YM = 11'd719;
    localparam int          SF = 8;
    localparam logic [10:0] OFF = 11'h7FF;

    logic clk = 0, rst_n = 0, v_sync_in = 0, enable = 1;
    logic c_valid = 0, c_ready, b_valid = 0, b_ready, valid_out, c_stale, b_stale;
    logic [10:0] c_x = 0, c_y = 0, b_min_x = 0, b_max_x = 0, b_min_y = 0, b_max_y = 0;
    logic [10:0] x_out, y_out, min_x_out, max_x_out, min_y_out, max_y_out;

    overlay_update_ctrl #(.IMG_W(1280), .IMG_H(720), .STALE_FRAMES(SF)) dut (
        .clk(clk), .rst_n(rst_n), .v_sync_in(v_sync_in), .enable(enable),
        .c_valid(c_valid), .c_ready(c_ready), .c_x(c_x), .c_y(c_y),
        .b_valid(b_valid), .b_ready(b_ready), .b_min_x(b_min_x), .b_max_x(b_max_x),
        .b_min_y(b_min_y), .b_max_y(b_max_y), .valid_out(valid_out),
        .x_out(x_out), .y_out(y_out), .min_x_out(min_x_out), .max_x_out(max_x_out),
        .min_y_out(min_y_out), .max_y_out(max_y_out), .c_stale(c_stale), .b_stale(b_stale)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] x, y, nx, xx, ny, xy;
        logic        cs, bs;
    } exp_t;

    exp_t sb[$];
    exp_t last_e, me;
    int n_tests = 0, n_fail = 0;
    int m_cc, m_bc;
    logic [10:0] m_cx, m_cy, m_nx, m_xx, m_ny, m_xy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] cl(input logic [10:0] v, input logic [10:0] m);
        return v > m ? m : v;
    endfunction

    function automatic int inc(input int c);
        return c == SF ? SF : c + 1;
    endfunction

    task automatic model_reset();
        {m_cx, m_cy, m_nx, m_xx, m_ny, m_xy} = '0;
        m_cc = SF;
        m_bc = SF;
    endtask

    task automatic m_acc_c(input logic [10:0] x, input logic [10:0] y);
        m_cx = cl(x, XM);
        m_cy = cl(y, YM);
        m_cc = 0;
    endtask

    task automatic model_fs(input bit commit, input bit wc, input logic [10:0] x, input logic [10:0] y);
        exp_t e;
        e.cs = wc ? 1'b0 : (m_cc == SF);
        e.bs = m_bc == SF;
        if (wc) m_acc_c(x, y);
        e.x  = e.cs ? OFF : m_cx;
        e.y  = e.cs ? OFF : m_cy;
        e.nx = e.bs ? OFF : m_nx;
        e.xx = e.bs ? OFF : m_xx;
        e.ny = e.bs ? OFF : m_ny;
        e.xy = e.bs ? OFF : m_xy;
        if (commit) begin
            sb.push_back(e);
            last_e = e;
        end
        m_cc = wc ? 0 : inc(m_cc);
        m_bc = inc(m_bc);
    endtask

    task automatic accept_c(input logic [10:0] x, input logic [10:0] y);
        int n = 0;
        @(posedge clk); #1;
        c_valid = 1; c_x = x; c_y = y;
        while (!c_ready && n < 10) begin @(posedge clk); #1; n++; end
        if (n == 10) chk("c_ready_timeout", 0, 1);
        @(posedge clk); #1;
        c_valid = 0;
        m_acc_c(x, y);
    endtask

    task automatic accept_b(input logic [10:0] nx, input logic [10:0] xx,
                            input logic [10:0] ny, input logic [10:0] xy);
        logic [10:0] a, b, c, d;
        int n = 0;
        @(posedge clk); #1;
        b_valid = 1; b_min_x = nx; b_max_x = xx; b_min_y = ny; b_max_y = xy;
        while (!b_ready && n < 10) begin @(posedge clk); #1; n++; end
        if (n == 10) chk("b_ready_timeout", 0, 1);
        @(posedge clk); #1;
        b_valid = 0;
        a = cl(nx, XM); b = cl(xx, XM); c = cl(ny, YM); d = cl(xy, YM);
        m_nx = a > b ? b : a; m_xx = a > b ? a : b;
        m_ny = c > d ? d : c; m_xy = c > d ? c : d;
        m_bc = 0;
    endtask

    task automatic frame(input bit commit, input bit wc, input logic [10:0] x, input logic [10:0] y);
        @(posedge clk); #1;
        v_sync_in = 1;
        if (wc) begin c_valid = 1; c_x = x; c_y = y; end
        model_fs(commit, wc, x, y);
        @(posedge clk); #1;
        v_sync_in = 0;
        c_valid = 0;
        @(negedge clk);
        if (commit) begin
            chk("load_c_ready", c_ready, 0);
            chk("load_b_ready", b_ready, 0);
        end
        chk("load_valid", valid_out, 0);
        @(negedge clk);
        chk("pulse_valid", valid_out, commit);
        @(negedge clk);
        chk("pulse_end", valid_out, 0);
        repeat (2) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && valid_out) begin
            if (sb.size() == 0) chk("spurious_pulse", 1, 0);
            else begin
                me = sb.pop_front();
                chk("x_out", x_out, me.x);
                chk("y_out", y_out, me.y);
                chk("min_x_out", min_x_out, me.nx);
                chk("max_x_out", max_x_out, me.xx);
                chk("min_y_out", min_y_out, me.ny);
                chk("max_y_out", max_y_out, me.xy);
                chk("c_stale", c_stale, me.cs);
                chk("b_stale", b_stale, me.bs);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_c_ready", c_ready, 0);
        chk("rst_valid", valid_out, 0);
        rst_n = 1;
        @(negedge clk);
        chk("rel_x", x_out, OFF);
        chk("rel_y", y_out, OFF);
        chk("rel_min_x", min_x_out, OFF);
        chk("rel_max_y", max_y_out, OFF);
        chk("rel_c_stale", c_stale, 1);
        chk("rel_b_stale", b_stale, 1);
        chk("rel_c_ready", c_ready, 1);
        chk("rel_b_ready", b_ready, 1);
        chk("rel_valid", valid_out, 0);

        accept_c(11'd100, 11'd50);
        frame(1, 0, 0, 0);

        accept_b(11'd1500, 11'd200, 11'd30, 11'd800);
        frame(1, 0, 0, 0);

        accept_c(11'd300, 11'd400);
        repeat (9) frame(1, 0, 0, 0);
        accept_c(11'd5, 11'd6);
        frame(1, 0, 0, 0);

        @(posedge clk); #1;
        v_sync_in = 1;
        model_fs(1, 0, 0, 0);
        @(posedge clk); #1;
        v_sync_in = 0;
        c_valid = 1; c_x = 11'd7; c_y = 11'd8;
        @(negedge clk);
        chk("coll_load_ready", c_ready, 0);
        @(posedge clk); #1;
        chk("coll_pulse_ready", c_ready, 1);
        @(posedge clk); #1;
        c_valid = 0;
        m_acc_c(11'd7, 11'd8);
        frame(1, 0, 0, 0);

        frame(1, 1, 11'd900, 11'd2000);

        enable = 0;
        repeat (3) frame(0, 0, 0, 0);
        chk("dis_x", x_out, last_e.x);
        chk("dis_y", y_out, last_e.y);
        chk("dis_min_x", min_x_out, last_e.nx);
        enable = 1;
        frame(1, 0, 0, 0);

        @(posedge clk); #1;
        v_sync_in = 1;
        model_fs(1, 0, 0, 0);
        @(posedge clk); #1;
        v_sync_in = 0;
        @(posedge clk); #1;
        v_sync_in = 1;
        model_fs(0, 0, 0, 0);
        chk("retrig_pulse", valid_out, 1);
        @(posedge clk); #1;
        v_sync_in = 0;
        repeat (4) begin @(negedge clk); chk("retrig_extra", valid_out, 0); end

        @(posedge clk); #1;
        v_sync_in = 1;
        @(posedge clk); #1;
        v_sync_in = 0;
        rst_n = 0;
        #1;
        chk("rload_valid", valid_out, 0);
        chk("rload_x", x_out, OFF);
        chk("rload_max_x", max_x_out, OFF);
        chk("rload_min_y", min_y_out, OFF);
        chk("rload_c_stale", c_stale, 1);
        chk("rload_b_stale", b_stale, 1);
        chk("rload_c_ready", c_ready, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        repeat (3) begin @(negedge clk); chk("rload_no_pulse", valid_out, 0); end

        accept_c(11'd11, 11'd22);
        frame(1, 0, 0, 0);

        repeat (5) @(posedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
